// File: rtl/addsub_pkg.sv
// Shared constants for the arbitrated slice-serial adder/subtractor:
// FSM encodings, operation modes and default geometry.
package addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic ADDSUB_SUB = 1'b0;
    localparam logic ADDSUB_ADD = 1'b1;

    localparam int unsigned ADDSUB_WIDTH = 8;
    localparam int unsigned ADDSUB_SLICE = 4;

endpackage

// File: rtl/addsub_shared_if.sv
// Two-client request/ready bundle for addsub_shared; master is the client side,
// slave is the shared arithmetic unit.
interface addsub_shared_if
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
);
    logic             req0_i;
    logic             mode0_i;
    logic [WIDTH-1:0] a0_i;
    logic [WIDTH-1:0] b0_i;
    logic             req1_i;
    logic             mode1_i;
    logic [WIDTH-1:0] a1_i;
    logic [WIDTH-1:0] b1_i;
    logic             ready0_o;
    logic             ready1_o;
    logic [WIDTH-1:0] res_o;
    logic             co_o;
    logic             busy_o;

    modport master (
        output req0_i, mode0_i, a0_i, b0_i,
        output req1_i, mode1_i, a1_i, b1_i,
        input  ready0_o, ready1_o, res_o, co_o, busy_o
    );

    modport slave (
        input  req0_i, mode0_i, a0_i, b0_i,
        input  req1_i, mode1_i, a1_i, b1_i,
        output ready0_o, ready1_o, res_o, co_o, busy_o
    );

endinterface

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder; inv_b_i turns b into ~b so that a carry-in of 1
// yields a - b.
module addsub_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             inv_b_i,
    input  logic             ci_i,
    output logic [SLICE-1:0] sum_o,
    output logic             co_o
);
    logic [SLICE-1:0] w_b;
    logic [SLICE:0]   w_full;

    assign w_b    = b_i ^ {SLICE{inv_b_i}};
    assign w_full = {1'b0, a_i} + {1'b0, w_b} + {{SLICE{1'b0}}, ci_i};
    assign sum_o  = w_full[SLICE-1:0];
    assign co_o   = w_full[SLICE];

endmodule

// File: rtl/addsub_shared.sv
// Round-robin shared adder/subtractor for two clients; operands are latched at grant
// and processed SLICE bits per cycle, LSB slice first.
module addsub_shared
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH,
    parameter int unsigned SLICE = ADDSUB_SLICE
) (
    input  logic           clk_i,
    input  logic           rst_i,
    addsub_shared_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    state_t           r_state;
    logic             r_grant;
    logic             r_last_grant;
    logic             r_op_m;
    logic             r_carry;
    logic             r_co;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any_req;
    logic             w_grant_nxt;
    logic             w_mode_sel;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic [SLICE-1:0] w_sum;
    logic             w_cout;
    logic             w_last_slice;
    logic [WIDTH-1:0] w_acc_nxt;

    // On a tie the client not served last wins; a lone request always wins.
    always_comb begin
        w_any_req   = bus.req0_i | bus.req1_i;
        w_grant_nxt = (bus.req0_i & bus.req1_i) ? ~r_last_grant : bus.req1_i;
        w_mode_sel  = w_grant_nxt ? bus.mode1_i : bus.mode0_i;
        w_a_sel     = w_grant_nxt ? bus.a1_i : bus.a0_i;
        w_b_sel     = w_grant_nxt ? bus.b1_i : bus.b0_i;
    end

    addsub_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i     (r_op_a[SLICE-1:0]),
        .b_i     (r_op_b[SLICE-1:0]),
        .inv_b_i (~r_op_m),
        .ci_i    (r_carry),
        .sum_o   (w_sum),
        .co_o    (w_cout)
    );

    assign w_acc_nxt    = {w_sum, r_acc[WIDTH-1:SLICE]};
    assign w_last_slice = (r_cnt == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op_m       <= 1'b0;
            r_carry      <= 1'b0;
            r_co         <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_acc        <= '0;
            r_res        <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant <= w_grant_nxt;
                        r_op_a  <= w_a_sel;
                        r_op_b  <= w_b_sel;
                        r_op_m  <= w_mode_sel;
                        r_carry <= ~w_mode_sel;
                        r_cnt   <= '0;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_acc   <= w_acc_nxt;
                    r_op_a  <= r_op_a >> SLICE;
                    r_op_b  <= r_op_b >> SLICE;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last_slice) begin
                        r_res   <= w_acc_nxt;
                        // Subtract reports borrow, which is the inverted carry.
                        r_co    <= (r_op_m == ADDSUB_ADD) ? w_cout : ~w_cout;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_last_grant <= r_grant;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready0_o = (r_state == ST_DONE) & ~r_grant;
    assign bus.ready1_o = (r_state == ST_DONE) & r_grant;
    assign bus.res_o    = r_res;
    assign bus.co_o     = r_co;
    assign bus.busy_o   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_addsub_shared.sv
// Directed bench for addsub_shared: single clients, borrow, contention, reset abort
// and a subtract-driven square-root client.
module tb_addsub_shared;
    import addsub_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk_i = ~clk_i;

    addsub_shared_if #(.WIDTH(WIDTH)) bus ();

    addsub_shared #(
        .WIDTH (WIDTH),
        .SLICE (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        bus.req0_i = 1'b0; bus.mode0_i = 1'b0; bus.a0_i = '0; bus.b0_i = '0;
        bus.req1_i = 1'b0; bus.mode1_i = 1'b0; bus.a1_i = '0; bus.b1_i = '0;
        tick(2);
        n_checks++;
        if ({bus.ready0_o, bus.ready1_o, bus.co_o, bus.busy_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got r0/r1/co/busy=%b want 0000",
                     {bus.ready0_o, bus.ready1_o, bus.co_o, bus.busy_o});
        end
        n_checks++;
        if (bus.res_o !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_res: got %0d want 0", bus.res_o);
        end
        rst_i = 1'b1;
        tick(1);
    endtask

    task automatic test_client0_sub();
        bus.req0_i = 1'b1; bus.mode0_i = ADDSUB_SUB; bus.a0_i = 8'd100; bus.b0_i = 8'd36;
        tick(1);
        n_checks++;
        if (bus.busy_o !== 1'b1 || bus.ready0_o !== 1'b0) begin
            n_fail++;
            $display("FAIL c0_cyc1: got busy=%b ready0=%b want 1 0", bus.busy_o, bus.ready0_o);
        end
        tick(1);
        n_checks++;
        if (bus.ready0_o !== 1'b0) begin
            n_fail++;
            $display("FAIL c0_cyc2: got ready0=%b want 0", bus.ready0_o);
        end
        tick(1);
        n_checks++;
        if (bus.ready0_o !== 1'b1 || bus.ready1_o !== 1'b0) begin
            n_fail++;
            $display("FAIL c0_ready: got r0=%b r1=%b want 1 0", bus.ready0_o, bus.ready1_o);
        end
        n_checks++;
        if (bus.res_o !== 8'd64 || bus.co_o !== 1'b0) begin
            n_fail++;
            $display("FAIL c0_result: got %0d co=%b want 64 co=0", bus.res_o, bus.co_o);
        end
        bus.req0_i = 1'b0;
        tick(1);
        n_checks++;
        if (bus.ready0_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL c0_after: got r0=%b busy=%b want 0 0", bus.ready0_o, bus.busy_o);
        end
    endtask

    task automatic test_client1_add();
        bus.req1_i = 1'b1; bus.mode1_i = ADDSUB_ADD; bus.a1_i = 8'd200; bus.b1_i = 8'd100;
        tick(3);
        n_checks++;
        if (bus.ready1_o !== 1'b1 || bus.ready0_o !== 1'b0) begin
            n_fail++;
            $display("FAIL c1_ready: got r1=%b r0=%b want 1 0", bus.ready1_o, bus.ready0_o);
        end
        n_checks++;
        if (bus.res_o !== 8'd44 || bus.co_o !== 1'b1) begin
            n_fail++;
            $display("FAIL c1_add_wrap: got %0d co=%b want 44 co=1", bus.res_o, bus.co_o);
        end
        bus.req1_i = 1'b0;
        tick(1);
    endtask

    task automatic test_borrow();
        bus.req0_i = 1'b1; bus.mode0_i = ADDSUB_SUB; bus.a0_i = 8'd5; bus.b0_i = 8'd9;
        tick(3);
        n_checks++;
        if (bus.ready0_o !== 1'b1 || bus.res_o !== 8'd252 || bus.co_o !== 1'b1) begin
            n_fail++;
            $display("FAIL borrow: got r0=%b res=%0d co=%b want 1 252 1",
                     bus.ready0_o, bus.res_o, bus.co_o);
        end
        bus.req0_i = 1'b0;
        tick(1);
    endtask

    task automatic test_contention();
        rst_i = 1'b0;
        bus.req0_i = 1'b1; bus.mode0_i = ADDSUB_SUB; bus.a0_i = 8'd64; bus.b0_i = 8'd16;
        bus.req1_i = 1'b1; bus.mode1_i = ADDSUB_ADD; bus.a1_i = 8'd3;  bus.b1_i = 8'd4;
        tick(1);
        rst_i = 1'b1;
        tick(3);
        n_checks++;
        if (bus.ready0_o !== 1'b1 || bus.ready1_o !== 1'b0 || bus.res_o !== 8'd48) begin
            n_fail++;
            $display("FAIL tie_first: got r0=%b r1=%b res=%0d want 1 0 48",
                     bus.ready0_o, bus.ready1_o, bus.res_o);
        end
        bus.req0_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick(1);
            n_checks++;
            if (bus.ready0_o !== 1'b0 || bus.ready1_o !== 1'b0) begin
                n_fail++;
                $display("FAIL tie_gap%0d: got r0=%b r1=%b want 0 0",
                         c, bus.ready0_o, bus.ready1_o);
            end
        end
        tick(1);
        n_checks++;
        if (bus.ready1_o !== 1'b1 || bus.res_o !== 8'd7 || bus.co_o !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_second: got r1=%b res=%0d co=%b want 1 7 0",
                     bus.ready1_o, bus.res_o, bus.co_o);
        end
        bus.req1_i = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_calc();
        bus.req1_i = 1'b1; bus.mode1_i = ADDSUB_ADD; bus.a1_i = 8'd10; bus.b1_i = 8'd20;
        tick(2);
        n_checks++;
        if (bus.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: got busy=%b want 1", bus.busy_o);
        end
        rst_i = 1'b0;
        #1;
        n_checks++;
        if ({bus.ready0_o, bus.ready1_o, bus.co_o, bus.busy_o} !== 4'b0000 ||
            bus.res_o !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got r0/r1/co/busy=%b res=%0d want 0000 0",
                     {bus.ready0_o, bus.ready1_o, bus.co_o, bus.busy_o}, bus.res_o);
        end
        tick(1);
        rst_i = 1'b1;
        tick(2);
        n_checks++;
        if (bus.ready1_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_early: got r1=%b want 0", bus.ready1_o);
        end
        tick(1);
        n_checks++;
        if (bus.ready1_o !== 1'b1 || bus.res_o !== 8'd30) begin
            n_fail++;
            $display("FAIL abort_reserve: got r1=%b res=%0d want 1 30",
                     bus.ready1_o, bus.res_o);
        end
        bus.req1_i = 1'b0;
        tick(1);
    endtask

    // Integer square root by subtracting successive odd numbers until a borrow.
    task automatic test_sqrt();
        logic [7:0] exp_res [10];
        logic [7:0] rem;
        int         y;
        bit         done;
        exp_res = '{8'd80, 8'd77, 8'd72, 8'd65, 8'd56, 8'd45, 8'd32, 8'd17, 8'd0, 8'd237};
        rem  = 8'd81;
        y    = 0;
        done = 1'b0;
        for (int k = 0; k < 10 && !done; k++) begin
            bus.req0_i = 1'b1; bus.mode0_i = ADDSUB_SUB;
            bus.a0_i = rem; bus.b0_i = 8'(2 * k + 1);
            tick(3);
            n_checks++;
            if (bus.ready0_o !== 1'b1 || bus.res_o !== exp_res[k] ||
                bus.co_o !== (k == 9)) begin
                n_fail++;
                $display("FAIL sqrt_step%0d: got r0=%b res=%0d co=%b want 1 %0d %b",
                         k, bus.ready0_o, bus.res_o, bus.co_o, exp_res[k], (k == 9));
            end
            if (bus.co_o === 1'b1) begin
                done = 1'b1;
            end else begin
                rem = bus.res_o;
                y++;
            end
            bus.req0_i = 1'b0;
            tick(1);
            n_checks++;
            if (bus.ready0_o !== 1'b0 || bus.busy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sqrt_once%0d: got r0=%b busy=%b want 0 0",
                         k, bus.ready0_o, bus.busy_o);
            end
        end
        n_checks++;
        if (y != 9) begin
            n_fail++;
            $display("FAIL sqrt_y: got %0d want 9", y);
        end
    endtask

    initial begin
        test_reset();
        test_client0_sub();
        test_client1_add();
        test_borrow();
        test_contention();
        test_reset_mid_calc();
        test_sqrt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
